// File: rtl/fp_pkg.sv
// Shared FP definitions: field widths, fflags bit positions, source indices
// and the write-back entry layout used by the result arbiter.
package fp_pkg;

    localparam int FP_FLAG_W = 5;
    localparam int FLAG_NV   = 4;
    localparam int FLAG_DZ   = 3;
    localparam int FLAG_OF   = 2;
    localparam int FLAG_UF   = 1;
    localparam int FLAG_NX   = 0;

    localparam int FREG_AW = 5;
    localparam int XLEN    = 32;

    localparam int SRC_FADD = 0;
    localparam int SRC_FMUL = 1;
    localparam int SRC_FDIV = 2;

    typedef struct packed {
        logic [FREG_AW-1:0]   rd;
        logic [XLEN-1:0]      data;
        logic [FP_FLAG_W-1:0] flags;
    } wb_entry_t;

    // A clear coinciding with a write keeps the new result's flags.
    function automatic logic [FP_FLAG_W-1:0] fflags_next(
        input logic                 clr,
        input logic                 grant,
        input logic [FP_FLAG_W-1:0] acc,
        input logic [FP_FLAG_W-1:0] flags
    );
        logic [FP_FLAG_W-1:0] res;
        case ({clr, grant})
            2'b11:   res = flags;
            2'b10:   res = {FP_FLAG_W{1'b0}};
            2'b01:   res = acc | flags;
            default: res = acc;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fp_wb_arbiter_wb_fifo.sv
// Per-source result FIFO. Ready is registered from the next occupancy so the
// producer sees no combinational path from its own valid.
module wb_fifo
    import fp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  wb_entry_t i_entry,
    input  logic      i_pop,
    output logic      o_ready,
    output logic      o_empty,
    output wb_entry_t o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t      r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           r_ready;

    logic           w_push;
    logic           w_pop;
    logic [CW-1:0]  w_count_next;

    assign w_push  = i_push & r_ready;
    assign w_pop   = i_pop & (r_count != {CW{1'b0}});
    assign o_ready = r_ready;
    assign o_empty = (r_count == {CW{1'b0}});
    assign o_head  = r_mem[r_rptr];

    // Next occupancy; simultaneous push and pop cancel out.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + {{(CW-1){1'b0}}, 1'b1};
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            w_count_next = r_count;
        end
    end

    // Storage array; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_entry;
        end
    end

    // Pointers, occupancy and registered ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
            r_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rptr <= r_rptr + {{(AW-1){1'b0}}, 1'b1};
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next != CW'(DEPTH));
        end
    end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP result write-back arbiter: buffers FADD/FMUL/FDIV results and drives the
// single FPR write port round-robin, accumulating sticky fflags.
module fp_wb_arbiter
    import fp_pkg::*;
#(
    parameter int N_SRC = 3,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_SRC-1:0]             src_valid,
    output logic [N_SRC-1:0]             src_ready,
    input  logic [FREG_AW*N_SRC-1:0]     src_rd,
    input  logic [XLEN*N_SRC-1:0]        src_data,
    input  logic [FP_FLAG_W*N_SRC-1:0]   src_flags,
    output logic                         reg_write,
    output logic [FREG_AW-1:0]           wa,
    output logic [XLEN-1:0]              data_write,
    output logic [1:0]                   wb_src,
    output logic [FP_FLAG_W-1:0]         fflags_acc,
    input  logic                         fflags_clr
);

    localparam int SW = 2;

    wb_entry_t             w_in   [N_SRC];
    wb_entry_t             w_head [N_SRC];
    wb_entry_t             w_gnt;
    logic [N_SRC-1:0]      w_empty;
    logic [N_SRC-1:0]      w_pop;
    logic                  w_grant_valid;
    logic [SW-1:0]         w_grant_idx;
    logic [SW-1:0]         w_scan;

    logic                  r_we;
    logic [FREG_AW-1:0]    r_wa;
    logic [XLEN-1:0]       r_data;
    logic [SW-1:0]         r_src;
    logic [SW-1:0]         r_rr;
    logic [FP_FLAG_W-1:0]  r_ff;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign w_in[g] = {src_rd[FREG_AW*g +: FREG_AW],
                          src_data[XLEN*g +: XLEN],
                          src_flags[FP_FLAG_W*g +: FP_FLAG_W]};

        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (src_valid[g]),
            .i_entry (w_in[g]),
            .i_pop   (w_pop[g]),
            .o_ready (src_ready[g]),
            .o_empty (w_empty[g]),
            .o_head  (w_head[g])
        );
    end

    // Round-robin search starting just after the last granted source.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = {SW{1'b0}};
        w_scan        = {SW{1'b0}};
        for (int k = 1; k <= N_SRC; k++) begin
            w_scan = SW'((int'(r_rr) + k) % N_SRC);
            if (!w_grant_valid && !w_empty[w_scan]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_scan;
            end else begin
                w_grant_valid = w_grant_valid;
            end
        end
    end

    // One-hot pop of the granted FIFO head.
    always_comb begin
        w_pop = {N_SRC{1'b0}};
        if (w_grant_valid) begin
            w_pop[w_grant_idx] = 1'b1;
        end else begin
            w_pop = {N_SRC{1'b0}};
        end
    end

    assign w_gnt = w_head[w_grant_idx];

    // FPR write port register, round-robin pointer and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_we   <= 1'b0;
            r_wa   <= {FREG_AW{1'b0}};
            r_data <= {XLEN{1'b0}};
            r_src  <= {SW{1'b0}};
            r_rr   <= SW'(N_SRC - 1);
            r_ff   <= {FP_FLAG_W{1'b0}};
        end else begin
            if (w_grant_valid) begin
                r_we   <= 1'b1;
                r_wa   <= w_gnt.rd;
                r_data <= w_gnt.data;
                r_src  <= w_grant_idx;
                r_rr   <= w_grant_idx;
            end else begin
                r_we   <= 1'b0;
            end
            r_ff <= fflags_next(fflags_clr, w_grant_valid, r_ff, w_gnt.flags);
        end
    end

    assign reg_write  = r_we;
    assign wa         = r_wa;
    assign data_write = r_data;
    assign wb_src     = r_src;
    assign fflags_acc = r_ff;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Self-checking bench for fp_wb_arbiter: directed vector table, backpressure and
// mid-burst reset sequences, then random traffic against a queue-based model.
module tb_fp_wb_arbiter;

    localparam int NS = 3;
    localparam int DP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [14:0] src_rd;
    logic [95:0] src_data;
    logic [14:0] src_flags;
    logic        reg_write;
    logic [4:0]  wa;
    logic [31:0] data_write;
    logic [1:0]  wb_src;
    logic [4:0]  fflags_acc;
    logic        fflags_clr;

    always #5 clk = ~clk;

    fp_wb_arbiter #(.N_SRC(NS), .DEPTH(DP)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_rd     (src_rd),
        .src_data   (src_data),
        .src_flags  (src_flags),
        .reg_write  (reg_write),
        .wa         (wa),
        .data_write (data_write),
        .wb_src     (wb_src),
        .fflags_acc (fflags_acc),
        .fflags_clr (fflags_clr)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  flags;
    } ent_t;

    typedef struct {
        logic        rst;
        logic [2:0]  v;
        logic [14:0] rd;
        logic [95:0] data;
        logic [14:0] fl;
        logic        clr;
        logic [2:0]  er;
        logic        ewe;
        logic [4:0]  ewa;
        logic [31:0] ed;
        logic [1:0]  es;
        logic [4:0]  ef;
    } vec_t;

    // Reference model: one queue of pending results per source.
    ent_t        mq [NS][$];
    int          m_rr;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_data;
    logic [1:0]  m_src;
    logic [4:0]  m_ff;
    logic [2:0]  m_ready;

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_edge();
        logic [2:0] acc;
        int   g;
        bit   found;
        ent_t e;
        if (!rst) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            m_rr = NS - 1; m_we = 1'b0; m_wa = 5'd0; m_data = 32'd0; m_src = 2'd0; m_ff = 5'd0;
        end else begin
            for (int i = 0; i < NS; i++) acc[i] = src_valid[i] && (mq[i].size() < DP);
            found = 1'b0; g = 0;
            for (int k = 1; k <= NS; k++) begin
                int c;
                c = (m_rr + k) % NS;
                if (!found && mq[c].size() > 0) begin
                    found = 1'b1; g = c;
                end
            end
            if (found) begin
                e = mq[g].pop_front();
                m_we = 1'b1; m_wa = e.rd; m_data = e.data; m_src = g[1:0]; m_rr = g;
                m_ff = fflags_clr ? e.flags : (m_ff | e.flags);
            end else begin
                m_we = 1'b0;
                if (fflags_clr) m_ff = 5'd0;
            end
            for (int i = 0; i < NS; i++) begin
                if (acc[i]) mq[i].push_back('{rd: src_rd[5*i +: 5], data: src_data[32*i +: 32],
                                              flags: src_flags[5*i +: 5]});
            end
        end
        for (int i = 0; i < NS; i++) m_ready[i] = (mq[i].size() < DP);
    endtask

    task automatic tick(input bit cm);
        if (cm) chk("src_ready", 32'(src_ready), 32'(m_ready));
        @(posedge clk);
        edge_cnt++;
        model_edge();
        #1;
        if (cm) begin
            chk("reg_write", 32'(reg_write), 32'(m_we));
            chk("wa", 32'(wa), 32'(m_wa));
            chk("data_write", data_write, m_data);
            chk("wb_src", 32'(wb_src), 32'(m_src));
            chk("fflags_acc", 32'(fflags_acc), 32'(m_ff));
        end
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [14:0] rd,
                                input logic [95:0] d, input logic [14:0] fl, input logic clr,
                                input logic [2:0] er, input logic ewe, input logic [4:0] ewa,
                                input logic [31:0] ed, input logic [1:0] es, input logic [4:0] ef);
        vec_t t;
        t.rst = r; t.v = v; t.rd = rd; t.data = d; t.fl = fl; t.clr = clr;
        t.er = er; t.ewe = ewe; t.ewa = ewa; t.ed = ed; t.es = es; t.ef = ef;
        return t;
    endfunction

    task automatic drive_idle(input logic clr);
        rst = 1'b1; src_valid = 3'b000; src_rd = 15'd0; src_data = 96'd0;
        src_flags = 15'd0; fflags_clr = clr;
    endtask

    int  lat;
    bit  saw_low;
    int  n_acc2;
    int  n_wr2;

    initial begin
        rst = 1'b0; src_valid = 3'b000; src_rd = 15'd0; src_data = 96'd0;
        src_flags = 15'd0; fflags_clr = 1'b0;
        @(negedge clk);
        tick(1'b0);

        // rst, valid, rd{2,1,0}, data{2,1,0}, flags{2,1,0}, clr | ready, we, wa, data, src, fflags
        tbl.push_back(mk(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hA, 32'hB, 32'hC}, 15'd0, 1'b0, 3'b111, 1'b0, 5'd0, 32'h0, 2'd0, 5'd0));
        tbl.push_back(mk(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hA, 32'hB, 32'hC}, 15'd0, 1'b0, 3'b111, 1'b0, 5'd0, 32'h0, 2'd0, 5'd0));
        tbl.push_back(mk(1'b1, 3'b000, 15'd0, 96'd0, 15'd0, 1'b0, 3'b111, 1'b0, 5'd0, 32'h0, 2'd0, 5'd0));
        tbl.push_back(mk(1'b1, 3'b000, 15'd0, 96'd0, 15'd0, 1'b0, 3'b111, 1'b0, 5'd0, 32'h0, 2'd0, 5'd0));
        tbl.push_back(mk(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h33, 32'h22, 32'h11}, 15'd0, 1'b0, 3'b111, 1'b0, 5'd0, 32'h0, 2'd0, 5'd0));
        tbl.push_back(mk(1'b1, 3'b000, 15'd0, 96'd0, 15'd0, 1'b0, 3'b111, 1'b1, 5'd1, 32'h11, 2'd0, 5'd0));
        tbl.push_back(mk(1'b1, 3'b000, 15'd0, 96'd0, 15'd0, 1'b0, 3'b111, 1'b1, 5'd2, 32'h22, 2'd1, 5'd0));
        tbl.push_back(mk(1'b1, 3'b111, {5'd6, 5'd5, 5'd4}, {32'h66, 32'h55, 32'h44}, 15'd0, 1'b0, 3'b111, 1'b1, 5'd3, 32'h33, 2'd2, 5'd0));
        tbl.push_back(mk(1'b1, 3'b000, 15'd0, 96'd0, 15'd0, 1'b0, 3'b111, 1'b1, 5'd4, 32'h44, 2'd0, 5'd0));
        tbl.push_back(mk(1'b1, 3'b000, 15'd0, 96'd0, 15'd0, 1'b0, 3'b111, 1'b1, 5'd5, 32'h55, 2'd1, 5'd0));
        tbl.push_back(mk(1'b1, 3'b000, 15'd0, 96'd0, 15'd0, 1'b0, 3'b111, 1'b1, 5'd6, 32'h66, 2'd2, 5'd0));
        tbl.push_back(mk(1'b1, 3'b000, 15'd0, 96'd0, 15'd0, 1'b0, 3'b111, 1'b0, 5'd6, 32'h66, 2'd2, 5'd0));
        tbl.push_back(mk(1'b1, 3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'h3F800000, 32'h0}, {5'd0, 5'b00001, 5'd0}, 1'b0, 3'b111, 1'b0, 5'd6, 32'h66, 2'd2, 5'd0));
        tbl.push_back(mk(1'b1, 3'b000, 15'd0, 96'd0, 15'd0, 1'b0, 3'b111, 1'b1, 5'd5, 32'h3F800000, 2'd1, 5'b00001));
        tbl.push_back(mk(1'b1, 3'b000, 15'd0, 96'd0, 15'd0, 1'b1, 3'b111, 1'b0, 5'd5, 32'h3F800000, 2'd1, 5'b00000));
        tbl.push_back(mk(1'b1, 3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h77}, {5'd0, 5'd0, 5'b01000}, 1'b0, 3'b111, 1'b0, 5'd5, 32'h3F800000, 2'd1, 5'b00000));
        tbl.push_back(mk(1'b1, 3'b001, {5'd0, 5'd0, 5'd8}, {32'h0, 32'h0, 32'h88}, {5'd0, 5'd0, 5'b00001}, 1'b0, 3'b111, 1'b1, 5'd7, 32'h77, 2'd0, 5'b01000));
        tbl.push_back(mk(1'b1, 3'b000, 15'd0, 96'd0, 15'd0, 1'b0, 3'b111, 1'b1, 5'd8, 32'h88, 2'd0, 5'b01001));
        tbl.push_back(mk(1'b1, 3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 32'h0, 32'h0}, {5'b00100, 5'd0, 5'd0}, 1'b0, 3'b111, 1'b0, 5'd8, 32'h88, 2'd0, 5'b01001));
        tbl.push_back(mk(1'b1, 3'b000, 15'd0, 96'd0, 15'd0, 1'b1, 3'b111, 1'b1, 5'd9, 32'h99, 2'd2, 5'b00100));
        tbl.push_back(mk(1'b1, 3'b000, 15'd0, 96'd0, 15'd0, 1'b1, 3'b111, 1'b0, 5'd9, 32'h99, 2'd2, 5'b00000));

        foreach (tbl[r]) begin
            rst = tbl[r].rst; src_valid = tbl[r].v; src_rd = tbl[r].rd; src_data = tbl[r].data;
            src_flags = tbl[r].fl; fflags_clr = tbl[r].clr;
            chk($sformatf("tbl%0d_ready", r), 32'(src_ready), 32'(tbl[r].er));
            tick(1'b1);
            chk($sformatf("tbl%0d_we", r), 32'(reg_write), 32'(tbl[r].ewe));
            chk($sformatf("tbl%0d_wa", r), 32'(wa), 32'(tbl[r].ewa));
            chk($sformatf("tbl%0d_data", r), data_write, tbl[r].ed);
            chk($sformatf("tbl%0d_src", r), 32'(wb_src), 32'(tbl[r].es));
            chk($sformatf("tbl%0d_fflags", r), 32'(fflags_acc), 32'(tbl[r].ef));
        end

        // FDIV held valid under full contention; FDIV data carries its accept edge.
        saw_low = 1'b0; n_acc2 = 0; n_wr2 = 0;
        for (int c = 0; c < 23; c++) begin
            if (c < 15) begin
                rst = 1'b1; src_valid = 3'b111; fflags_clr = 1'b0;
                src_rd = 15'($urandom); src_flags = 15'd0;
                src_data = {32'(edge_cnt + 1), $urandom, $urandom};
                if (!src_ready[2]) saw_low = 1'b1;
                if (src_ready[2]) n_acc2++;
            end else begin
                drive_idle(1'b0);
            end
            tick(1'b1);
            if (reg_write && wb_src == 2'd2) begin
                n_wr2++;
                lat = edge_cnt - int'(data_write) + 1;
                chk("bp_fdiv_latency", 32'(lat >= 2 && lat <= 6), 32'd1);
            end
        end
        chk("bp_ready_drop", 32'(saw_low), 32'd1);
        chk("bp_fdiv_count", 32'(n_wr2), 32'(n_acc2));

        // Reset with results buffered in every FIFO.
        for (int c = 0; c < 3; c++) begin
            rst = 1'b1; src_valid = 3'b111; fflags_clr = 1'b0;
            src_rd = 15'($urandom); src_data = {$urandom, $urandom, $urandom}; src_flags = 15'($urandom);
            tick(1'b1);
        end
        rst = 1'b0;
        tick(1'b1);
        chk("rst_mid_we", 32'(reg_write), 32'd0);
        chk("rst_mid_ff", 32'(fflags_acc), 32'd0);
        for (int c = 0; c < 6; c++) begin
            drive_idle(1'b0);
            tick(1'b1);
            chk("rst_no_stale", 32'(reg_write), 32'd0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(99) != 0);
            src_valid  = 3'($urandom);
            src_rd     = 15'($urandom);
            src_data   = {$urandom, $urandom, $urandom};
            src_flags  = 15'($urandom);
            fflags_clr = ($urandom_range(7) == 0);
            tick(1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
Collects results from the FP functional units (FADD/FSUB, FMUL, FDIV/FSQRT), buffers each source in a small FIFO, and grants them round-robin. It drives the single write port of the 32x32 FP register file with one write per cycle. It also accumulates exception flags for fcsr.fflags. It sits between the FP execution units and the FP register file write port (reg_write / wa / data_write).

Parameters:
N_SRC, 3, number of result sources (index 0 = FADD, 1 = FMUL, 2 = FDIV)
DEPTH, 2, entries per source FIFO (power of two, ≥2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-low
src_valid  in  N_SRC  per-source result valid
src_ready  out  N_SRC  per-source accept; registered, equals FIFO not full
src_rd  in  5*N_SRC  destination f-register per source; slice i = [5i+4:5i]
src_data  in  32*N_SRC  result data per source; slice i = [32i+31:32i]
src_flags  in  5*N_SRC  NV,DZ,OF,UF,NX per source
reg_write  out  1  FPR write enable (registered)
wa  out  5  FPR write address (registered)
data_write  out  32  FPR write data (registered)
wb_src  out  2  source index of the current write (for debug and scoreboard clear)
fflags_acc  out  5  sticky OR of flags of all written results
fflags_clr  in  1  clear fflags_acc (csr write)

Behaviour:
- Reset (rst=0 at a rising edge):
  - all FIFOs empty; src_ready = all 1s
  - reg_write=0, wa=0, data_write=0, wb_src=0, fflags_acc=0
  - rr pointer = N_SRC-1, so source 0 has first priority
- Reset mid-operation discards all buffered results. No write is issued in the reset cycle.
- Source handshake:
  - a transfer occurs when src_valid[i] & src_ready[i] at an edge
  - src_ready[i] is a function of the registered occupancy only; it has no combinational path from src_valid
  - a push to a full FIFO cannot occur
- FIFO:
  - per source, DEPTH entries of {rd, data, flags}, with wrapping read/write pointers and an occupancy counter of width log2(DEPTH)+1
  - a push and a pop in the same cycle leaves the count unchanged; this is legal even when full (ready was 0, so no push) and when empty (no pop)
- Arbitration (combinational, from FIFO heads):
  - the candidate set is the non-empty FIFOs
  - the grant goes to the first candidate searching upward (mod N_SRC) from rr+1
  - on a grant, the granted head is popped and rr is updated to the granted index
  - with no candidates, rr is held
- Output register:
  - on a grant: reg_write=1, wa=head.rd, data_write=head.data, wb_src=grant index
  - otherwise reg_write=0; wa, data_write and wb_src hold their previous values
- Latency: a result accepted at edge N is at its FIFO head during cycle N+1. If granted, reg_write=1 is visible during cycle N+2, and the FPR captures it on its next write edge. Minimum latency is 2 cycles; worst case under contention is 2+(N_SRC-1)*DEPTH cycles.
- Throughput: one write per cycle sustained. No backpressure comes from the FPR side.
- wa=0 is forwarded unchanged; no filtering is done in this block.
- Same-register ordering: two results to the same rd from different sources are written in grant order. Ordering is the ROB's responsibility, not this block's.
- fflags_acc next-state:
  - fflags_clr & grant → head.flags
  - fflags_clr & no grant → 0
  - grant only → fflags_acc | head.flags
  - otherwise → hold
  - the flags are those of the granted entry in the same edge that loads reg_write

Decomposition:
- Shared package fp_pkg:
  - FP_FLAG_W=5
  - flag bit indices NV=4, DZ=3, OF=2, UF=1, NX=0
  - FREG_AW=5, XLEN=32
  - source index constants SRC_FADD=0, SRC_FMUL=1, SRC_FDIV=2
- Sub-module wb_fifo (sync FIFO: push/pop/full/empty/head, DEPTH param), instantiated N_SRC times via generate.
- Arbiter and output register stay in the top.

Test Plan:
- Reset: hold rst=0 for 2 edges with src_valid=3'b111 → src_ready=3'b111, reg_write=0, fflags_acc=0, no FIFO entries after release.
- Single source: FMUL pushes rd=5, data=32'h3F800000, flags=5'b00001 at edge N → reg_write=1, wa=5, data_write=32'h3F800000, wb_src=1 during cycle N+2; fflags_acc=5'b00001.
- Round-robin: all three sources push (rd=1/2/3) in the same cycle → writes in consecutive cycles with wa order 1,2,3; a second simultaneous burst (rd=4/5/6) → order 4,5,6, with no source starved.
- Full/backpressure: FDIV holds valid with DEPTH=2 while FADD/FMUL stream continuously → src_ready[2] drops to 0 after 2 accepts; no entry is lost, and all FDIV results appear within 2+2*2 cycles of acceptance.
- fflags: accumulate DZ then NX → 5'b01001; assert fflags_clr in the same cycle as a grant carrying OF → fflags_acc=5'b00100; fflags_clr alone → 0.
- Reset mid-burst: rst=0 with 2 entries buffered per source → next cycle reg_write=0, and no stale write appears after release.
